bin2bcd_seq: RTL

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one shift per clock.
- Sits directly upstream of the BCD-to-Excess-3 encoder. Each 4-bit digit of its BCD result feeds one encoder instance.
- Uses a start/busy/done handshake so a controller can issue one conversion at a time.

---
 rtl/bin2bcd_seq_if.sv | 16 +
 rtl/bin2bcd_seq.sv | 101 ++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle for the sequential binary-to-BCD converter.
// The master side is the issuing controller and the slave side is the converter.
interface bin2bcd_seq_if #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) ();
  logic           start;
  logic [W-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;
  logic           ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Result digits beyond D are dropped and reported through ovf.
module bin2bcd_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned BW = 4 * D;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned TW = BW + W;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [W-1:0]    sreg;
  logic [BW-1:0]   scratch;
  logic [CW-1:0]   cnt;
  logic            ovf_acc;
  logic            busy_reg;
  logic            done_reg;
  logic            ovf_reg;
  logic [BW-1:0]   bcd_reg;

  logic [BW-1:0]   adj;
  logic [TW-1:0]   shifted;
  logic            shift_out;
  logic            last;

  // Add-3 correction on every digit that would reach 10 or more after doubling.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < int'(D); i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  assign shifted   = {adj, sreg} << 1;
  assign shift_out = adj[BW-1];
  assign last      = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      bcd_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            sreg     <= bus.bin;
            scratch  <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            busy_reg <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[TW-1:W];
          sreg    <= shifted[W-1:0];
          ovf_acc <= ovf_acc | shift_out;
          cnt     <= cnt + CW'(1);
          // Final iteration publishes the result directly from the shift network.
          if (last) begin
            bcd_reg  <= shifted[TW-1:W];
            ovf_reg  <= ovf_acc | shift_out;
            done_reg <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.bcd  = bcd_reg;
  assign bus.ovf  = ovf_reg;

endmodule
